// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, byte type, drop counter width and the
// FIFO operation encoding used by the receive buffer.
package uart_pkg;

    localparam int UART_DBIT  = 8;
    localparam int DROP_CNT_W = 8;

    typedef logic [UART_DBIT-1:0] uart_byte_t;

    // Encoded as {pop, write} so the buffer can cast its two enables directly.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DBIT register array with one synchronous write port and one
// asynchronous read port; contents are deliberately not reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DBIT = UART_DBIT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DBIT-1:0]   wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DBIT-1:0]   rdata_o
);

    logic [DBIT-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: first-word-fall-through
// valid/ready output, drop-on-full with sticky overrun and saturating loss count.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DBIT = UART_DBIT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_done_tick,
    input  logic [DBIT-1:0]       din,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DBIT-1:0]       m_data,
    output logic [ADDR_W:0]       count,
    output logic                  full,
    output logic                  empty,
    output logic                  overrun,
    input  logic                  overrun_clr,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]       count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overrun_q, overrun_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic     pop;
    logic     wr_en;
    logic     drop;
    fifo_op_e op;

    // A pop frees the head slot in the same cycle, so a full FIFO can still
    // accept the incoming byte when the consumer is draining.
    always_comb begin
        pop   = ~empty_q & m_ready;
        wr_en = rx_done_tick & (~full_q | pop);
        drop  = rx_done_tick & full_q & ~pop;
        op    = fifo_op_e'({pop, wr_en});
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        case (op)
            FIFO_PUSH: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end
            FIFO_POP: begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
            end
            FIFO_BOTH: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            default: begin
                count_d = count_q;
            end
        endcase
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    // A drop in the same cycle as a clear wins, leaving a count of one.
    always_comb begin
        overrun_d  = overrun_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overrun_d  = 1'b1;
            drop_cnt_d = overrun_clr ? DROP_CNT_W'(1) : sat_inc(drop_cnt_q);
        end else if (overrun_clr) begin
            overrun_d  = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH(DEPTH),
        .DBIT (DBIT)
    ) u_mem (
        .clk    (clk),
        .we_i   (wr_en),
        .waddr_i(wr_ptr_q),
        .wdata_i(din),
        .raddr_i(rd_ptr_q),
        .rdata_o(m_data)
    );

    assign m_valid  = ~empty_q;
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign overrun  = overrun_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo (DEPTH=4): directed scenarios followed by
// random traffic, checked against a queue-based model of the buffer.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rx_done_tick;
    logic [7:0]    din;
    logic          m_valid;
    logic          m_ready;
    logic [7:0]    m_data;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overrun;
    logic          overrun_clr;
    logic [7:0]    drop_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] refQ[$];
    logic [7:0] expQ[$];
    int         refDrops = 0;
    bit         refOvr = 1'b0;
    bit         modelPop;
    bit         modelDrop;

    uart_rx_fifo #(
        .DEPTH(DEPTH),
        .DBIT (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_done_tick(rx_done_tick),
        .din         (din),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    // Inputs change 1ns after a rising edge and are held for one full cycle.
    task automatic applyStimulus(input logic s, input logic [7:0] d, input logic r, input logic c);
        rx_done_tick = s;
        din          = d;
        m_ready      = r;
        overrun_clr  = c;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        m_ready      = 1'b0;
        overrun_clr  = 1'b0;
    endtask

    task automatic fillFifo(input logic [7:0] base);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, base + 8'(i), 1'b0, 1'b0);
        end
    endtask

    task automatic drainFifo();
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    // Reference model: a byte queue with drop-on-full and a saturating loss count.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refQ.delete();
            expQ.delete();
            refOvr   = 1'b0;
            refDrops = 0;
        end else begin
            modelPop  = (refQ.size() > 0) && m_ready;
            modelDrop = 1'b0;
            if (rx_done_tick) begin
                if (refQ.size() < DEPTH || modelPop) begin
                    refQ.push_back(din);
                    expQ.push_back(din);
                end else begin
                    modelDrop = 1'b1;
                end
            end
            if (modelPop) refQ.delete(0);
            if (modelDrop) begin
                refOvr   = 1'b1;
                refDrops = overrun_clr ? 1 : ((refDrops < 255) ? refDrops + 1 : 255);
            end else if (overrun_clr) begin
                refOvr   = 1'b0;
                refDrops = 0;
            end
        end
    end

    // Monitor: compares flags every cycle and retires the head byte on handshake.
    always @(negedge clk) begin
        if (reset_n) begin
            checkOutput("m_valid", int'(m_valid), int'(refQ.size() > 0));
            checkOutput("count", int'(count), refQ.size());
            checkOutput("full", int'(full), int'(refQ.size() == DEPTH));
            checkOutput("empty", int'(empty), int'(refQ.size() == 0));
            checkOutput("overrun", int'(overrun), int'(refOvr));
            checkOutput("drop_cnt", int'(drop_cnt), refDrops);
            if (m_valid) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL m_data: got 0x%0h expected no valid byte at %0t", m_data, $time);
                end else begin
                    checkOutput("m_data", int'(m_data), int'(expQ[0]));
                    if (m_ready) expQ.delete(0);
                end
            end
        end
    end

    initial begin
        reset_n      = 1'b0;
        rx_done_tick = 1'b0;
        din          = 8'h00;
        m_ready      = 1'b0;
        overrun_clr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        checkOutput("reset count", int'(count), 0);
        checkOutput("reset empty", int'(empty), 1);
        checkOutput("reset full", int'(full), 0);
        checkOutput("reset m_valid", int'(m_valid), 0);
        checkOutput("reset overrun", int'(overrun), 0);
        checkOutput("reset drop_cnt", int'(drop_cnt), 0);

        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        checkOutput("first m_valid", int'(m_valid), 1);
        checkOutput("first m_data", int'(m_data), 8'h55);
        checkOutput("first count", int'(count), 1);
        checkOutput("first empty", int'(empty), 0);
        repeat (10) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("held m_data", int'(m_data), 8'h55);
        drainFifo();

        fillFifo(8'h01);
        checkOutput("fill full", int'(full), 1);
        checkOutput("fill count", int'(count), DEPTH);
        drainFifo();
        checkOutput("drain empty", int'(empty), 1);
        checkOutput("drain m_valid", int'(m_valid), 0);

        fillFifo(8'h01);
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        checkOutput("drop overrun", int'(overrun), 1);
        checkOutput("drop drop_cnt", int'(drop_cnt), 1);
        checkOutput("drop head", int'(m_data), 8'h01);
        checkOutput("drop count", int'(count), DEPTH);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("clr overrun", int'(overrun), 0);
        checkOutput("clr drop_cnt", int'(drop_cnt), 0);

        applyStimulus(1'b1, 8'hBB, 1'b1, 1'b0);
        checkOutput("full pop+push count", int'(count), DEPTH);
        checkOutput("full pop+push overrun", int'(overrun), 0);
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("last byte", int'(m_data), 8'hBB);
        drainFifo();

        fillFifo(8'h20);
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
        checkOutput("sat drop_cnt", int'(drop_cnt), 255);
        checkOutput("sat overrun", int'(overrun), 1);
        applyStimulus(1'b1, 8'hCC, 1'b0, 1'b1);
        checkOutput("clr+drop overrun", int'(overrun), 1);
        checkOutput("clr+drop drop_cnt", int'(drop_cnt), 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        drainFifo();

        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
        checkOutput("wrap head", int'(m_data), 8'h1A);
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
        checkOutput("wrap count", int'(count), 2);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async rst count", int'(count), 0);
        checkOutput("async rst m_valid", int'(m_valid), 0);
        checkOutput("async rst empty", int'(empty), 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 8'h7E, 1'b0, 1'b0);
        checkOutput("post-reset m_data", int'(m_data), 8'h7E);
        checkOutput("post-reset count", int'(count), 1);
        drainFifo();

        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 99) < 60, 8'($urandom),
                          $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3);
        end
        drainFifo();
        checkOutput("final empty", int'(empty), 1);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
